// File: rtl/cpu_dbg_pkg.sv
// Shared types and helpers for the halt/dump run-control block.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {RUN, FETCH, WAIT, SEND, DONE} state_e;

  localparam logic [31:0] HALT_INSTR_DFLT = 32'hFFFF_FFFF;

  function automatic logic is_last(input logic [31:0] addr, input logic [31:0] words);
    return addr == (words - 32'd1);
  endfunction

endpackage

// File: rtl/cpu_halt_dump_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)              q <= '0;
    else if (inc && !(&q)) q <= q + W'(1);
  end

endmodule

// File: rtl/cpu_halt_dump_ctrl.sv
// Run-control for the pipeline: watches writeback for halt/timeout, then
// streams DUMP_WORDS data-memory words out over valid/ready.
module cpu_halt_dump_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 9,
  parameter int          DUMP_WORDS = 512,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DFLT,
  parameter int          CYC_W      = 32,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [31:0]       instrW,
  input  logic              instr_valid_W,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [CYC_W-1:0]  retired_count
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_q;
  logic              to_q;
  logic              run, halt, tmo, hs, last, retire;
  logic [CYC_W-1:0]  cyc_inc;

  assign run     = (state == RUN);
  assign halt    = run && instr_valid_W && (instrW == HALT_INSTR);
  assign retire  = run && instr_valid_W && (instrW != HALT_INSTR);
  // Timeout compares against the value cycle_count is about to take.
  assign cyc_inc = (&cycle_count) ? cycle_count : cycle_count + CYC_W'(1);
  assign tmo     = (TIMEOUT != 0) && run && !halt && (64'(cyc_inc) == 64'(TIMEOUT));
  assign last    = is_last(32'(addr), 32'(DUMP_WORDS));
  assign hs      = (state == SEND) && dump_ready;

  sat_counter #(.W(CYC_W)) u_cyc (
    .clk (CLK),
    .rst (reset),
    .inc (run),
    .q   (cycle_count)
  );

  sat_counter #(.W(CYC_W)) u_ret (
    .clk (CLK),
    .rst (reset),
    .inc (retire),
    .q   (retired_count)
  );

  always_ff @(posedge CLK) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt || tmo) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = SEND;
      SEND:    if (hs) state_nxt = last ? DONE : FETCH;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    mem_rd_en  = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      FETCH:   begin mem_rd_en = 1'b1; busy = 1'b1; end
      WAIT:    busy = 1'b1;
      SEND:    begin dump_valid = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // addr only moves on a non-last handshake, so it is stable through SEND
  // and already points at the next word when FETCH is entered.
  always_ff @(posedge CLK) begin
    if (reset) begin
      addr   <= '0;
      data_q <= '0;
      to_q   <= 1'b0;
    end else begin
      if (hs && !last)     addr   <= addr + ADDR_W'(1);
      if (state == WAIT)   data_q <= mem_rd_data;
      if (tmo)             to_q   <= 1'b1;
    end
  end

  assign mem_rd_addr = addr;
  assign dump_addr   = addr;
  assign dump_data   = data_q;
  assign dump_last   = (state == SEND) && last;
  assign timed_out   = to_q;

endmodule

// File: tb/tb_cpu_halt_dump_ctrl.sv
// Three differently-parameterised instances share stimulus; a word-level
// model per instance predicts every output each cycle.
module tb_cpu_halt_dump_ctrl;

  localparam int N = 3;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  function automatic int f_aw(input int g); return (g == 2) ? 2 : 9;  endfunction
  function automatic int f_cw(input int g); return (g == 2) ? 4 : 32; endfunction
  function automatic int f_to(input int g); return (g == 1) ? 20 : 0; endfunction
  function automatic int f_nw(input int g); return (g == 1) ? 5 : 4;  endfunction

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instrW = '0;
  logic        instr_valid_W = 1'b0;
  logic        dump_ready = 1'b0;

  always #5 CLK = ~CLK;

  logic [N-1:0]       o_en, o_valid, o_last, o_busy, o_done, o_to;
  logic [N-1:0][31:0] o_raddr, o_data, o_daddr, o_cyc, o_ret;

  for (genvar g = 0; g < N; g++) begin : gd
    localparam int AW = f_aw(g);
    localparam int CW = f_cw(g);
    logic [AW-1:0] rd_addr, daddr;
    logic [31:0]   rd_data, ddata;
    logic [CW-1:0] cc, rc;
    logic          en, vld, lst, bsy, dn, tmo;

    cpu_halt_dump_ctrl #(
      .DATA_W(32), .ADDR_W(AW), .DUMP_WORDS(f_nw(g)), .HALT_INSTR(HALT),
      .CYC_W(CW), .TIMEOUT(f_to(g))
    ) dut (
      .CLK(CLK), .reset(reset), .instrW(instrW), .instr_valid_W(instr_valid_W),
      .mem_rd_en(en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
      .dump_valid(vld), .dump_ready(dump_ready), .dump_data(ddata),
      .dump_addr(daddr), .dump_last(lst), .busy(bsy), .done(dn),
      .timed_out(tmo), .cycle_count(cc), .retired_count(rc)
    );

    // memory[i] = i+100; read data is junk except the cycle after a strobe
    always @(posedge CLK) rd_data <= en ? (32'(rd_addr) + 32'd100) : $urandom;

    assign o_en[g] = en;   assign o_valid[g] = vld; assign o_last[g] = lst;
    assign o_busy[g] = bsy; assign o_done[g] = dn;  assign o_to[g] = tmo;
    assign o_raddr[g] = 32'(rd_addr); assign o_data[g] = ddata;
    assign o_daddr[g] = 32'(daddr);   assign o_cyc[g] = 32'(cc);
    assign o_ret[g] = 32'(rc);
  end

  // model: ph 0=running 1=dumping 2=finished; sub = cycle within a word
  int     ph[N], w[N], sub[N], to[N];
  longint cyc[N], ret[N];
  int     vec = 0, err = 0;

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] ins, input logic iv, input logic rdy);
    for (int k = 0; k < N; k++) begin
      longint cmax = (64'd1 << f_cw(k)) - 1;
      if (r) begin
        ph[k] = 0; w[k] = 0; sub[k] = 0; to[k] = 0; cyc[k] = 0; ret[k] = 0;
      end else if (ph[k] == 0) begin
        bit     h  = iv && (ins == HALT);
        longint nc = (cyc[k] + 1 > cmax) ? cmax : cyc[k] + 1;
        if (iv && !h && ret[k] < cmax) ret[k]++;
        cyc[k] = nc;
        if (h) begin
          ph[k] = 1; w[k] = 0; sub[k] = 0;
        end else if (f_to(k) != 0 && nc == longint'(f_to(k))) begin
          ph[k] = 1; w[k] = 0; sub[k] = 0; to[k] = 1;
        end
      end else if (ph[k] == 1) begin
        if (sub[k] < 2) sub[k]++;
        else if (rdy) begin
          if (w[k] == f_nw(k) - 1) ph[k] = 2;
          else begin w[k]++; sub[k] = 0; end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      bit v = (ph[k] == 1) && (sub[k] == 2);
      chk("busy",      k, o_busy[k],  ph[k] == 1);
      chk("done",      k, o_done[k],  ph[k] == 2);
      chk("rd_en",     k, o_en[k],    (ph[k] == 1) && (sub[k] == 0));
      chk("rd_addr",   k, o_raddr[k], w[k]);
      chk("valid",     k, o_valid[k], v);
      chk("last",      k, o_last[k],  v && (w[k] == f_nw(k) - 1));
      chk("cycles",    k, o_cyc[k],   cyc[k]);
      chk("retired",   k, o_ret[k],   ret[k]);
      chk("timed_out", k, o_to[k],    to[k]);
      if (v) begin
        chk("data", k, o_data[k],  w[k] + 100);
        chk("addr", k, o_daddr[k], w[k]);
      end
    end
  endtask

  task automatic tick(input logic r, input logic [31:0] ins, input logic iv, input logic rdy);
    reset = r; instrW = ins; instr_valid_W = iv; dump_ready = rdy;
    step(r, ins, iv, rdy);
    @(negedge CLK);
    compare_all();
  endtask

  function automatic logic [31:0] rnd_instr();
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  // mode 0: ready=1, mode 1: stall dut0 word 1 for 3 cycles, mode 2: random
  task automatic drain(input int mode);
    int n = 0, hc = 0, ens;
    bit rdy, held;
    logic [31:0] ins;
    ens = o_en[0] ? 1 : 0;
    while ((ph[0] != 2 || ph[1] != 2 || ph[2] != 2) && n < 300) begin
      ins  = ($urandom_range(0, 3) == 0) ? HALT : rnd_instr();
      rdy  = (mode == 2) ? 1'($urandom) : 1'b1;
      held = 1'b0;
      if (mode == 1 && ph[0] == 1 && w[0] == 1 && sub[0] == 2 && hc < 3) begin
        rdy = 1'b0; held = 1'b1; hc++;
      end
      tick(1'b0, ins, 1'($urandom), rdy);
      if (o_en[0]) ens++;
      if (held) begin
        chk("bp_data", 0, o_data[0], 101);
        chk("bp_addr", 0, o_daddr[0], 1);
      end
      n++;
    end
    for (int k = 0; k < N; k++) begin
      chk("drain_done", k, o_done[k], 1);
      chk("drain_busy", k, o_busy[k], 0);
    end
    if (mode == 1) chk("bp_rd_en_count", 0, ens, 4);
  endtask

  initial begin
    // halt after 7 valid + 2 bubbles (one bubble carries the sentinel)
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    for (int c = 1; c <= 9; c++)
      tick(0, (c == 3) ? HALT : rnd_instr(), !(c == 3 || c == 6), 1);
    tick(0, HALT, 1, 1);
    chk("s1_cyc", 0, o_cyc[0], 10);
    chk("s1_ret", 0, o_ret[0], 7);
    chk("s1_model_ret", 0, ret[0], 7);
    tick(0, rnd_instr(), 1, 1);
    chk("s1_w0_early", 0, o_valid[0], 0);
    tick(0, rnd_instr(), 1, 1);
    chk("s1_w0_valid", 0, o_valid[0], 1);
    chk("s1_w0_data", 0, o_data[0], 100);
    chk("s1_w0_addr", 0, o_daddr[0], 0);
    drain(0);
    chk("s1_to", 0, o_to[0], 0);
    for (int i = 0; i < 4; i++) tick(0, HALT, 1, 1);
    chk("s1_done_hold", 0, o_done[0], 1);

    // backpressure on word 1
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 11; c++) tick(0, rnd_instr(), 1'($urandom), 1'($urandom));
    tick(0, HALT, 1, 1);
    drain(1);

    // timeout on dut1, saturation on dut2
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 39; c++) begin
      tick(0, rnd_instr(), 1, 1'($urandom));
      if (c == 20) begin
        chk("s3_to", 1, o_to[1], 1);
        chk("s3_cyc", 1, o_cyc[1], 20);
        chk("s3_busy", 1, o_busy[1], 1);
      end
    end
    tick(0, HALT, 1, 1);
    chk("s3_sat_cyc", 2, o_cyc[2], 15);
    chk("s3_sat_ret", 2, o_ret[2], 15);
    chk("s3_cyc", 0, o_cyc[0], 40);
    chk("s3_ret", 0, o_ret[0], 39);
    chk("s3_frozen", 1, o_cyc[1], 20);
    drain(2);
    chk("s3_to_end", 1, o_to[1], 1);

    // halt and timeout in the same cycle: halt wins
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 19; c++) tick(0, rnd_instr(), 1, 1);
    tick(0, HALT, 1, 1);
    chk("s4_to", 1, o_to[1], 0);
    chk("s4_cyc", 1, o_cyc[1], 20);
    drain(0);

    // reset after word 2 accepted, then a fresh dump from address 0
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 4; c++) tick(0, rnd_instr(), 1, 1);
    tick(0, HALT, 1, 1);
    for (int i = 0; i < 50 && !(ph[0] == 1 && w[0] == 3 && sub[0] == 0); i++)
      tick(0, rnd_instr(), 1, 1);
    chk("s5_reached", 0, o_daddr[0], 3);
    tick(1, rnd_instr(), 1, 1);
    chk("s5_valid", 0, o_valid[0], 0);
    chk("s5_busy", 0, o_busy[0], 0);
    chk("s5_cyc", 0, o_cyc[0], 0);
    chk("s5_ret", 0, o_ret[0], 0);
    tick(0, rnd_instr(), 1, 1); tick(0, rnd_instr(), 1, 1);
    tick(0, HALT, 1, 1);
    tick(0, 0, 0, 1); tick(0, 0, 0, 1);
    chk("s5_restart_addr", 0, o_daddr[0], 0);
    chk("s5_restart_data", 0, o_data[0], 100);
    drain(0);

    // random runs with occasional resets
    for (int r = 0; r < 6; r++) begin
      tick(1, 0, 0, 0);
      for (int i = 0; i < int'($urandom_range(5, 60)); i++)
        tick($urandom_range(0, 49) == 0,
             ($urandom_range(0, 15) == 0) ? HALT : rnd_instr(),
             1'($urandom), 1'($urandom));
      tick(0, HALT, 1, 1);
      drain(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
